// File: rtl/em4100_pkg.sv
// Shared constants and FSM state encoding for the EM4100 reader-side decoder.
package em4100_pkg;

  localparam int HEADER_ONES = 9;
  localparam int NUM_ROWS    = 10;
  localparam int ROW_BITS    = 4;
  localparam int COL_BITS    = 4;
  localparam int ID_BITS     = 40;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ROWS = 2'd1,
    COLS = 2'd2,
    STOP = 2'd3
  } state_e;

endpackage

// File: rtl/manchester_halfbit_sampler.sv
// Synchronises the raw Manchester line and emits one sample per half-bit,
// re-centring the sample point on every line edge; flags a silent line as idle.
module manchester_halfbit_sampler #(
  parameter int HALF_BIT_CYCLES = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int IDLE_HALVES     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sample_valid,
  output logic sample_bit,
  output logic idle
);

  localparam int IDLE_LIMIT = IDLE_HALVES * HALF_BIT_CYCLES;
  localparam int TW         = $clog2(IDLE_LIMIT + 1);
  localparam int PW         = $clog2(HALF_BIT_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic [TW-1:0]          timer_q, timer_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic                   edge_w;

  assign edge_w = sync_q[SYNC_STAGES-1] ^ level_q;

  always_comb begin
    timer_d = timer_q;
    phase_d = phase_q;
    if (edge_w) begin
      timer_d = '0;
      phase_d = '0;
    end else begin
      if (timer_q != TW'(IDLE_LIMIT)) timer_d = timer_q + 1'b1;
      phase_d = (phase_q == PW'(HALF_BIT_CYCLES - 1)) ? '0 : phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      timer_q <= '0;
      phase_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      level_q <= sync_q[SYNC_STAGES-1];
      timer_q <= timer_d;
      phase_q <= phase_d;
    end
  end

  // phase_q restarts with the timer on each edge, so the sample lands mid half-bit.
  assign idle         = (timer_q == TW'(IDLE_LIMIT));
  assign sample_valid = !idle && (phase_q == PW'(HALF_BIT_CYCLES / 2 - 1));
  assign sample_bit   = level_q;

endmodule

// File: rtl/em4100_decoder.sv
// EM4100 frame decoder: pairs half-bit samples into bits, hunts the 9-one header,
// checks row/column parity and stop bit, and publishes the 40-bit ID.
module em4100_decoder
  import em4100_pkg::*;
#(
  parameter int HALF_BIT_CYCLES = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int IDLE_HALVES     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               din,
  output logic [ID_BITS-1:0] data_out,
  output logic               data_valid,
  output logic               parity_err,
  output logic               busy
);

  logic sample_valid, sample_bit, idle;

  manchester_halfbit_sampler #(
    .HALF_BIT_CYCLES(HALF_BIT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES),
    .IDLE_HALVES    (IDLE_HALVES)
  ) u_sampler (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .sample_valid(sample_valid),
    .sample_bit  (sample_bit),
    .idle        (idle)
  );

  state_e               state_q, state_d;
  logic [3:0]           hdr_cnt_q, hdr_cnt_d;
  logic [3:0]           row_q, row_d;
  logic [2:0]           col_q, col_d;
  logic                 half_q, half_d;
  logic                 half_vld_q, half_vld_d;
  logic [ID_BITS-1:0]   work_q, work_d;
  logic                 row_par_q, row_par_d;
  logic [COL_BITS-1:0]  col_par_q, col_par_d;
  logic                 err_q, err_d;
  logic [ID_BITS-1:0]   data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 bit_vld, bit_val, pair_bad;

  always_comb begin
    state_d      = state_q;
    hdr_cnt_d    = hdr_cnt_q;
    row_d        = row_q;
    col_d        = col_q;
    half_d       = half_q;
    half_vld_d   = half_vld_q;
    work_d       = work_q;
    row_par_d    = row_par_q;
    col_par_d    = col_par_q;
    err_d        = err_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = 1'b0;
    bit_vld      = 1'b0;
    bit_val      = 1'b0;
    pair_bad     = 1'b0;

    // Equal halves mean we are paired across a bit boundary: keep the newer half.
    if (sample_valid) begin
      if (!half_vld_q) begin
        half_d     = sample_bit;
        half_vld_d = 1'b1;
      end else if (half_q != sample_bit) begin
        bit_vld    = 1'b1;
        bit_val    = half_q;
        half_vld_d = 1'b0;
      end else begin
        half_d   = sample_bit;
        pair_bad = 1'b1;
      end
    end

    if (!en || idle || pair_bad) begin
      state_d   = HUNT;
      hdr_cnt_d = '0;
      row_d     = '0;
      col_d     = '0;
      row_par_d = 1'b0;
      col_par_d = '0;
      err_d     = 1'b0;
      if (!en || idle) half_vld_d = 1'b0;
    end else if (bit_vld) begin
      unique case (state_q)
        HUNT: begin
          if (!bit_val) begin
            hdr_cnt_d = '0;
          end else if (hdr_cnt_q == 4'(HEADER_ONES - 1)) begin
            state_d   = ROWS;
            hdr_cnt_d = '0;
            row_d     = '0;
            col_d     = '0;
            row_par_d = 1'b0;
            col_par_d = '0;
            err_d     = 1'b0;
          end else begin
            hdr_cnt_d = hdr_cnt_q + 1'b1;
          end
        end
        ROWS: begin
          if (col_q == 3'(ROW_BITS)) begin
            if (bit_val != row_par_q) err_d = 1'b1;
            row_par_d = 1'b0;
            col_d     = '0;
            if (row_q == 4'(NUM_ROWS - 1)) begin
              state_d = COLS;
              row_d   = '0;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            work_d                 = {work_q[ID_BITS-2:0], bit_val};
            row_par_d              = row_par_q ^ bit_val;
            col_par_d[col_q[1:0]]  = col_par_q[col_q[1:0]] ^ bit_val;
            col_d                  = col_q + 1'b1;
          end
        end
        COLS: begin
          if (bit_val != col_par_q[col_q[1:0]]) err_d = 1'b1;
          if (col_q == 3'(COL_BITS - 1)) begin
            state_d = STOP;
            col_d   = '0;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        STOP: begin
          state_d   = HUNT;
          hdr_cnt_d = '0;
          if (err_q || bit_val) begin
            parity_err_d = 1'b1;
          end else begin
            data_valid_d = 1'b1;
            data_out_d   = work_q;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      hdr_cnt_q    <= '0;
      row_q        <= '0;
      col_q        <= '0;
      half_q       <= 1'b0;
      half_vld_q   <= 1'b0;
      work_q       <= '0;
      row_par_q    <= 1'b0;
      col_par_q    <= '0;
      err_q        <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      row_q        <= row_d;
      col_q        <= col_d;
      half_q       <= half_d;
      half_vld_q   <= half_vld_d;
      work_q       <= work_d;
      row_par_q    <= row_par_d;
      col_par_q    <= col_par_d;
      err_q        <= err_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign busy       = (state_q != HUNT);

endmodule

// File: tb/tb_em4100_decoder.sv
// Directed bench for em4100_decoder: a frame encoder feeds a Manchester line,
// and a monitor scores every data_valid pulse against an expected-ID queue.
module tb_em4100_decoder;

  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        din = 1'b0;
  logic [39:0] data_out;
  logic        data_valid, parity_err, busy;

  int          checks   = 0;
  int          errors   = 0;
  int          vld_cnt  = 0;
  int          perr_cnt = 0;
  logic [39:0] exp_q[$];
  logic        hs[$];

  typedef struct {
    logic [39:0] id_a;
    int          flip;
    int          skip;
    bit          two;
    logic [39:0] id_b;
    int          exp_n;
    logic [39:0] exp_v0;
    logic [39:0] exp_v1;
    int          exp_perr;
    logic [39:0] exp_out;
  } vec_t;

  vec_t vecs[7];

  em4100_decoder #(
    .HALF_BIT_CYCLES(H),
    .SYNC_STAGES    (2),
    .IDLE_HALVES    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din       (din),
    .data_out  (data_out),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every data_valid pulse must match the oldest expected ID.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) begin
        vld_cnt++;
        if (exp_q.size() == 0) chk("unexpected_valid", data_out, 40'hx);
        else chk("valid_data_out", data_out, exp_q.pop_front());
      end
      if (parity_err) perr_cnt++;
      if (data_valid || parity_err) chk("pulses_exclusive", {39'd0, data_valid & parity_err}, 40'd0);
    end
  end

  task automatic add_bit(input logic b);
    hs.push_back(b);
    hs.push_back(~b);
  endtask

  task automatic add_frame(input logic [39:0] id, input int flip);
    logic       fb[64];
    logic [3:0] nib;
    logic [3:0] cp;
    logic       rp;
    int         p;
    p  = 0;
    cp = '0;
    for (int k = 0; k < 9; k++) begin fb[p] = 1'b1; p++; end
    for (int r = 0; r < 10; r++) begin
      nib = id[39-4*r -: 4];
      rp  = 1'b0;
      for (int k = 0; k < 4; k++) begin
        fb[p] = nib[3-k];
        rp    = rp ^ nib[3-k];
        cp[k] = cp[k] ^ nib[3-k];
        p++;
      end
      fb[p] = rp;
      p++;
    end
    for (int k = 0; k < 4; k++) begin fb[p] = cp[k]; p++; end
    fb[p] = 1'b0;
    if (flip >= 0) fb[flip] = ~fb[flip];
    for (int b = 0; b < 64; b++) add_bit(fb[b]);
  endtask

  // Drives the queued halves; each real edge moves by at most 2 cycles from the
  // previous one and stays within +/-jmax of its ideal position.
  task automatic emit(input int jmax);
    int i, n, run, d_cur, d_nxt, lo, hi;
    d_cur = 0;
    i     = 0;
    n     = hs.size();
    while (i < n) begin
      run = 1;
      while (i + run < n && hs[i+run] == hs[i]) run++;
      if (i + run >= n) begin
        d_nxt = 0;
      end else begin
        lo    = (d_cur - 2 < -jmax) ? -jmax : d_cur - 2;
        hi    = (d_cur + 2 > jmax) ? jmax : d_cur + 2;
        d_nxt = lo + int'($urandom_range(0, hi - lo));
      end
      din = hs[i];
      repeat (run * H + d_nxt - d_cur) @(negedge clk);
      d_cur = d_nxt;
      i     = i + run;
    end
    hs.delete();
  endtask

  task automatic trim(input int keep);
    while (hs.size() > keep) hs.delete(hs.size() - 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    din = 1'b0;
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    en       = 1'b1;
    vld_cnt  = 0;
    perr_cnt = 0;
    exp_q.delete();
  endtask

  task automatic settle();
    repeat (6 * H) @(negedge clk);
  endtask

  initial begin
    logic [39:0] id;
    logic [39:0] last_id;

    vecs[0] = '{40'h0123456789, -1, 0,  1'b0, 40'h0, 1, 40'h0123456789, 40'h0, 0, 40'h0123456789};
    vecs[1] = '{40'h0123456789, 28, 0,  1'b0, 40'h0, 0, 40'h0, 40'h0, 1, 40'h0};
    vecs[2] = '{40'h0123456789, 10, 0,  1'b0, 40'h0, 0, 40'h0, 40'h0, 1, 40'h0};
    vecs[3] = '{40'h0123456789, 60, 0,  1'b0, 40'h0, 0, 40'h0, 40'h0, 1, 40'h0};
    vecs[4] = '{40'h0123456789, 63, 0,  1'b0, 40'h0, 0, 40'h0, 40'h0, 1, 40'h0};
    vecs[5] = '{40'hA5A5A5A5A5, -1, 0,  1'b1, 40'hFFFFFFFFFF, 2, 40'hA5A5A5A5A5, 40'hFFFFFFFFFF, 0, 40'hFFFFFFFFFF};
    vecs[6] = '{40'hDEADBEEF01, -1, 37, 1'b0, 40'h0, 1, 40'hDEADBEEF01, 40'h0, 0, 40'hDEADBEEF01};

    repeat (2) @(negedge clk);
    chk("reset_data_out", data_out, 40'h0);
    chk("reset_flags", {37'd0, data_valid, parity_err, busy}, 40'h0);

    for (int v = 0; v < 7; v++) begin
      do_reset();
      if (vecs[v].skip > 0) begin
        add_frame(vecs[v].id_a, -1);
        repeat (vecs[v].skip) hs.delete(0);
      end else begin
        add_bit(1'b0);
      end
      add_frame(vecs[v].id_a, vecs[v].flip);
      if (vecs[v].two) add_frame(vecs[v].id_b, -1);
      if (vecs[v].exp_n > 0) exp_q.push_back(vecs[v].exp_v0);
      if (vecs[v].exp_n > 1) exp_q.push_back(vecs[v].exp_v1);
      emit(0);
      settle();
      chk($sformatf("v%0d_valid_cnt", v), 40'(vld_cnt), 40'(vecs[v].exp_n));
      chk($sformatf("v%0d_perr_cnt", v), 40'(perr_cnt), 40'(vecs[v].exp_perr));
      chk($sformatf("v%0d_data_out", v), data_out, vecs[v].exp_out);
    end

    // Line goes silent mid-ROWS, then a full frame follows.
    do_reset();
    add_bit(1'b0);
    add_frame(40'h1122334455, -1);
    trim(2 + 2 * (9 + 20));
    emit(0);
    chk("idle_busy_mid_rows", {39'd0, busy}, 40'd1);
    repeat (5 * H) @(negedge clk);
    chk("idle_abort_busy", {39'd0, busy}, 40'd0);
    add_bit(1'b0);
    add_frame(40'h13579BDF02, -1);
    exp_q.push_back(40'h13579BDF02);
    emit(0);
    settle();
    chk("idle_recover_valid_cnt", 40'(vld_cnt), 40'd1);
    chk("idle_recover_perr_cnt", 40'(perr_cnt), 40'd0);
    chk("idle_recover_data_out", data_out, 40'h13579BDF02);

    // Asynchronous reset in the middle of a frame.
    add_bit(1'b0);
    add_frame(40'h2468ACE013, -1);
    trim(2 + 2 * 30);
    emit(0);
    chk("rst_busy_before", {39'd0, busy}, 40'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_data_out", data_out, 40'h0);
    chk("rst_async_flags", {37'd0, data_valid, parity_err, busy}, 40'h0);

    // Jittered stream of back-to-back random frames.
    do_reset();
    add_bit(1'b0);
    for (int f = 0; f < 20; f++) begin
      id = {8'($urandom_range(0, 255)), 32'($urandom())};
      exp_q.push_back(id);
      add_frame(id, -1);
      last_id = id;
    end
    emit(2);
    settle();
    chk("jitter_valid_cnt", 40'(vld_cnt), 40'd20);
    chk("jitter_perr_cnt", 40'(perr_cnt), 40'd0);
    chk("jitter_data_out", data_out, last_id);
    chk("jitter_queue_drained", 40'(exp_q.size()), 40'd0);

    // Enable dropped mid-frame: abort, data_out held, clean decode afterwards.
    vld_cnt  = 0;
    perr_cnt = 0;
    add_bit(1'b0);
    add_frame(40'h0F0F0F0F0F, -1);
    trim(2 + 2 * 30);
    emit(0);
    chk("en_busy_before", {39'd0, busy}, 40'd1);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("en_low_busy", {39'd0, busy}, 40'd0);
    chk("en_low_data_held", data_out, last_id);
    en = 1'b1;
    add_bit(1'b0);
    add_frame(40'h0F0F0F0F0F, -1);
    exp_q.push_back(40'h0F0F0F0F0F);
    emit(0);
    settle();
    chk("en_recover_valid_cnt", 40'(vld_cnt), 40'd1);
    chk("en_recover_perr_cnt", 40'(perr_cnt), 40'd0);
    chk("en_recover_data_out", data_out, 40'h0F0F0F0F0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
